// File: rtl/key_filter_pkg.sv
// Shared constants, state encoding and helpers for the four-key input conditioner.
package key_filter_pkg;

   localparam int unsigned NUM_KEYS    = 4;
   localparam int unsigned KEY_IDX_W   = $clog2(NUM_KEYS);
   // 20 ms window at 50 MHz, expressed as cycles minus one
   localparam int unsigned DEF_CNT_MAX = 999_999;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } kf_state_e;

   // Lowest set bit wins: key 0 has the highest priority.
   function automatic logic [KEY_IDX_W-1:0] prio_enc(input logic [NUM_KEYS-1:0] v);
      logic [KEY_IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = KEY_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_filter_if.sv
// Key input and conditioned output bundle between the board keys and downstream consumers.
interface key_filter_if;
   import key_filter_pkg::*;

   logic [NUM_KEYS-1:0]  key_in;
   logic [NUM_KEYS-1:0]  key_press;
   logic [NUM_KEYS-1:0]  key_release;
   logic [NUM_KEYS-1:0]  key_state;
   logic                 key_flag;
   logic [KEY_IDX_W-1:0] key_value;

   modport slave (
      input  key_in,
      output key_press, key_release, key_state, key_flag, key_value
   );

   modport master (
      output key_in,
      input  key_press, key_release, key_state, key_flag, key_value
   );

endinterface

// File: rtl/key_filter_debounce_1ch.sv
// Single-key conditioner: 2-FF synchroniser, debounce FSM with a private window counter.
module key_debounce_1ch
   import key_filter_pkg::*;
#(
   parameter int unsigned CNT_MAX = DEF_CNT_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_o,
   output logic rel_o,
   output logic state_o
);

   localparam int unsigned   CW       = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

   logic [1:0]    sync_q;
   logic          key_s;
   kf_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;

   // Synchroniser resets to "released" so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], key_i};
   end

   assign key_s = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!key_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (key_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSED: begin
            if (key_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            // A bounce back low returns to PRESSED silently; no second press pulse.
            if (!key_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign press_o = press_q;
   assign rel_o   = rel_q;
   assign state_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_filter.sv
// Four-key conditioner top: per-key debouncers plus registered pulses, levels, flag and key index.
module key_filter
   import key_filter_pkg::*;
#(
   parameter int unsigned CNT_MAX = DEF_CNT_MAX
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   key_filter_if.slave  kif
);

   logic [NUM_KEYS-1:0]  press_w, rel_w, state_w;
   logic [NUM_KEYS-1:0]  press_q, rel_q, state_q;
   logic                 flag_q;
   logic [KEY_IDX_W-1:0] value_q, value_d;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_1ch #(
         .CNT_MAX (CNT_MAX)
      ) u_ch (
         .clk     (sys_clk),
         .rst_n   (sys_rst_n),
         .key_i   (kif.key_in[i]),
         .press_o (press_w[i]),
         .rel_o   (rel_w[i]),
         .state_o (state_w[i])
      );
   end

   // Index only moves on a press; releases and idle cycles keep the last one.
   always_comb begin
      value_d = value_q;
      if (|press_w) value_d = prio_enc(press_w);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         press_q <= '0;
         rel_q   <= '0;
         state_q <= '0;
         flag_q  <= 1'b0;
         value_q <= '0;
      end else begin
         press_q <= press_w;
         rel_q   <= rel_w;
         state_q <= state_w;
         flag_q  <= |press_w;
         value_q <= value_d;
      end
   end

   assign kif.key_press   = press_q;
   assign kif.key_release = rel_q;
   assign kif.key_state   = state_q;
   assign kif.key_flag    = flag_q;
   assign kif.key_value   = value_q;

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter: run-length debounce model predicts pulses, monitor compares.
module tb_key_filter;

   localparam int CM  = 9;        // debounce CNT_MAX used here
   localparam int RUN = CM + 2;   // consecutive opposite samples needed to flip a level
   localparam int LAT = 3;        // cycles from the last qualifying sample to the output

   typedef struct {
      int       cyc;
      logic [3:0] pm;
      logic [3:0] rm;
      logic [3:0] st;
      logic [1:0] val;
   } ev_t;

   logic sys_clk;
   logic sys_rst_n;
   int   cyc;
   int   checks;
   int   errors;
   ev_t  expq[$];

   key_filter_if kif ();

   key_filter #(
      .CNT_MAX (CM)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .kif       (kif)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [1:0] lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
      return 2'd0;
   endfunction

   // Reference model: a key's debounced level flips once it has seen RUN
   // consecutive samples of the opposite level; the flip shows LAT cycles later.
   initial begin : model
      logic [3:0] lvl;
      int         run [4];
      logic [1:0] last_val;
      logic [3:0] pm, rm;
      ev_t        e;
      lvl      = '0;
      last_val = '0;
      cyc      = 0;
      for (int k = 0; k < 4; k++) run[k] = 0;
      forever begin
         @(posedge sys_clk);
         cyc++;
         if (!sys_rst_n) begin
            lvl      = '0;
            last_val = '0;
            for (int k = 0; k < 4; k++) run[k] = 0;
            expq.delete();
         end else begin
            pm = '0;
            rm = '0;
            for (int k = 0; k < 4; k++) begin
               if (!kif.key_in[k] != lvl[k]) begin
                  run[k]++;
                  if (run[k] == RUN) begin
                     lvl[k] = ~lvl[k];
                     run[k] = 0;
                     if (lvl[k]) pm[k] = 1'b1;
                     else        rm[k] = 1'b1;
                  end
               end else begin
                  run[k] = 0;
               end
            end
            if ((pm | rm) != 4'b0) begin
               if (pm != 4'b0) last_val = lowest(pm);
               e.cyc = cyc + LAT;
               e.pm  = pm;
               e.rm  = rm;
               e.st  = lvl;
               e.val = last_val;
               expq.push_back(e);
            end
         end
      end
   end

   initial begin : monitor
      logic [3:0] exp_st;
      logic [1:0] exp_val;
      ev_t        e;
      logic       pulse;
      exp_st  = '0;
      exp_val = '0;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            chk("reset_outputs",
                {1'b0, kif.key_press, kif.key_release, kif.key_state, kif.key_flag, kif.key_value},
                16'h0000);
            expq.delete();
            exp_st  = '0;
            exp_val = '0;
         end else begin
            pulse = (kif.key_press != 4'b0) || (kif.key_release != 4'b0) || kif.key_flag;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
               e = expq.pop_front();
               chk("key_press",   16'(kif.key_press),   16'(e.pm));
               chk("key_release", 16'(kif.key_release), 16'(e.rm));
               chk("key_flag",    16'(kif.key_flag),    16'(e.pm != 4'b0));
               exp_st  = e.st;
               exp_val = e.val;
            end else if (pulse) begin
               chk("unexpected_pulse",
                   {3'b0, kif.key_press, kif.key_release, kif.key_flag, 4'b0}, 16'h0000);
            end
            chk("state_value", {10'b0, kif.key_state, kif.key_value}, {10'b0, exp_st, exp_val});
         end
      end
   end

   task automatic hold(input logic [3:0] v, input int n);
      kif.key_in = v;
      repeat (n) @(posedge sys_clk);
      #2;
   endtask

   initial begin : stim
      logic [3:0] kv;
      int         dur [4];
      checks       = 0;
      errors       = 0;
      sys_rst_n    = 1'b0;
      kif.key_in   = 4'b0000;
      repeat (5) @(posedge sys_clk);
      #2;
      // all keys held low through reset release
      sys_rst_n = 1'b1;
      hold(4'b0000, 30);
      hold(4'b1111, 30);
      // clean press on key 2
      hold(4'b1011, 40);
      hold(4'b1111, 30);
      // bouncing press on key 1
      hold(4'b1101, 5);
      hold(4'b1111, 2);
      hold(4'b1101, 30);
      hold(4'b1111, 30);
      // short glitch on key 3
      hold(4'b0111, 8);
      hold(4'b1111, 20);
      // simultaneous press on keys 0 and 3
      hold(4'b0110, 30);
      hold(4'b1111, 30);
      // reset in the middle of a press window, key kept low
      hold(4'b1101, 7);
      sys_rst_n = 1'b0;
      hold(4'b1101, 3);
      sys_rst_n = 1'b1;
      hold(4'b1101, 30);
      // short release must not report
      hold(4'b1111, 5);
      hold(4'b1101, 20);
      hold(4'b1111, 30);
      // random bouncing on all keys, with one reset in the middle
      kv = 4'b1111;
      for (int k = 0; k < 4; k++) dur[k] = $urandom_range(1, 24);
      for (int c = 0; c < 2000; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (dur[k] == 0) begin
               kv[k]  = ~kv[k];
               dur[k] = $urandom_range(1, 24);
            end
            dur[k]--;
         end
         if (c == 1000) sys_rst_n = 1'b0;
         if (c == 1003) sys_rst_n = 1'b1;
         hold(kv, 1);
      end
      hold(4'b1111, 40);
      chk("queue_drained", 16'(expq.size()), 16'h0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
